// File: rtl/cpu_core_if.sv
// Instruction-fetch and data-memory bus between cpu_core (master) and its memories (slave).
interface cpu_core_if #(
   parameter int DW = 8,
   parameter int AW = 8
);
   localparam int IW = 14 + DW;

   logic [AW-1:0] im_addr;
   logic [IW-1:0] im_data;
   logic          dm_req;
   logic          dm_we;
   logic [DW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ready;

   modport master (
      output im_addr, dm_req, dm_we, dm_addr, dm_wdata,
      input  im_data, dm_rdata, dm_ready
   );

   modport slave (
      input  im_addr, dm_req, dm_we, dm_addr, dm_wdata,
      output im_data, dm_rdata, dm_ready
   );
endinterface

// File: rtl/cpu_core.sv
// Horizontally microcoded single-issue core with a stalling data-memory port and halt state.
// Optional retired-instruction counter enabled by defining CPU_PERF_CNT_EN.
module cpu_core #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   cpu_core_if.master        bus,
   output logic [DW-1:0]     alu_result,
   output logic [3:0]        status_out,
   output logic [AW-1:0]     pc_out,
   output logic              halted,
   output logic [31:0]       instr_count
);
   localparam int IW = 14 + DW;

   typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_HALT} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]    status_q, status_d;

   logic          ld_a, ld_b, mrd, mwr;
   logic [1:0]    sel_a, sel_b;
   logic [2:0]    alu_s, jc;
   logic [DW-1:0] lit;
   logic [AW-1:0] target;

   assign ld_a   = bus.im_data[IW-1];
   assign ld_b   = bus.im_data[IW-2];
   assign sel_a  = bus.im_data[IW-3:IW-4];
   assign sel_b  = bus.im_data[IW-5:IW-6];
   assign alu_s  = bus.im_data[IW-7:IW-9];
   assign mrd    = bus.im_data[IW-10];
   assign mwr    = bus.im_data[IW-11];
   assign jc     = bus.im_data[IW-12:IW-14];
   assign lit    = bus.im_data[DW-1:0];
   assign target = lit[AW-1:0];

   logic [DW-1:0] op_a, op_b, alu_r;
   logic          flag_c, flag_v;
   logic          jump_taken, halt_hit, mem_op, commit;

   always_comb begin
      op_a = '0;
      unique case (sel_a)
         2'd0: op_a = a_q;
         2'd1: op_a = b_q;
         2'd2: op_a = DW'(1);
         default: op_a = '0;
      endcase
      op_b = '0;
      unique case (sel_b)
         2'd0: op_b = b_q;
         2'd1: op_b = bus.dm_rdata;
         2'd2: op_b = lit;
         default: op_b = '0;
      endcase
   end

   always_comb begin
      alu_r  = '0;
      flag_c = 1'b0;
      flag_v = 1'b0;
      unique case (alu_s)
         3'd0: begin
            {flag_c, alu_r} = {1'b0, op_a} + {1'b0, op_b};
            flag_v = (op_a[DW-1] == op_b[DW-1]) && (alu_r[DW-1] != op_a[DW-1]);
         end
         3'd1: begin
            alu_r  = op_a - op_b;
            flag_c = (op_a >= op_b);
            flag_v = (op_a[DW-1] != op_b[DW-1]) && (alu_r[DW-1] != op_a[DW-1]);
         end
         3'd2: alu_r = op_a & op_b;
         3'd3: alu_r = op_a | op_b;
         3'd4: alu_r = op_a ^ op_b;
         3'd5: alu_r = ~op_a;
         3'd6: begin
            alu_r  = op_a << 1;
            flag_c = op_a[DW-1];
         end
         default: begin
            alu_r  = op_a >> 1;
            flag_c = op_a[0];
         end
      endcase
   end

   // Conditions look at the flags committed by the previous instruction.
   always_comb begin
      jump_taken = 1'b0;
      unique case (jc)
         3'd0: jump_taken = 1'b0;
         3'd1: jump_taken = 1'b1;
         3'd2: jump_taken = status_q[3];
         3'd3: jump_taken = !status_q[3];
         3'd4: jump_taken = status_q[2];
         3'd5: jump_taken = !status_q[2];
         3'd6: jump_taken = status_q[1];
         default: jump_taken = !status_q[1];
      endcase
   end

   assign mem_op   = mrd | mwr;
   assign halt_hit = (jc == 3'd1) && (target == pc_q);
   assign commit   = ((state_q == ST_RUN) && !halt_hit && !mem_op) ||
                     ((state_q == ST_MEM_WAIT) && bus.dm_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (halt_hit)    state_d = ST_HALT;
            else if (mem_op) state_d = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (bus.dm_ready) state_d = ST_RUN;
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_comb begin
      bus.dm_req = (state_q == ST_MEM_WAIT);
      halted     = (state_q == ST_HALT);
   end

   always_comb begin
      pc_d     = pc_q;
      a_d      = a_q;
      b_d      = b_q;
      status_d = status_q;
      if (commit) begin
         if (ld_a) a_d = alu_r;
         if (ld_b) b_d = alu_r;
         status_d = {(alu_r == '0), alu_r[DW-1], flag_c, flag_v};
         pc_d     = jump_taken ? target : pc_q + AW'(1);
      end
   end

   // A simultaneous MRD+MWR behaves as a write because dm_we follows MWR alone.
   assign bus.im_addr  = pc_q;
   assign bus.dm_we    = mwr;
   assign bus.dm_addr  = lit;
   assign bus.dm_wdata = a_q;
   assign alu_result   = alu_r;
   assign status_out   = status_q;
   assign pc_out       = pc_q;

`ifdef CPU_PERF_CNT_EN
   logic [31:0] icnt_q, icnt_d;

   always_comb begin
      icnt_d = icnt_q;
      if (commit) icnt_d = icnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) icnt_q <= '0;
      else     icnt_q <= icnt_d;
   end

   assign instr_count = icnt_q;
`else
   assign instr_count = '0;
`endif
endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Parametrised successor of the single-cycle computer: PC, A/B registers, operand muxes, ALU and status flags in one block.
- Adds synchronous reset, a data-memory port with a req/ready handshake (stall FSM), conditional jumps on registered flags, and a halt state.
- Instruction memory is external and combinationally read.
- Instruction word is horizontally microcoded, so no separate control unit is needed.

Parameters:
- DW, 8, datapath width (registers, ALU, literal, data memory).
- AW, 8, PC / instruction address width; AW <= DW.
- IW, 14+DW, instruction width; fixed by format, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- im_addr  out  AW  equals pc
- im_data  in  IW  instruction at im_addr, valid same cycle
- dm_req  out  1  data-memory request
- dm_we  out  1  1 = write, 0 = read; valid while dm_req
- dm_addr  out  DW  equals literal k; valid while dm_req
- dm_wdata  out  DW  equals regA; valid while dm_req
- dm_rdata  in  DW  read data; sampled when dm_ready
- dm_ready  in  1  completes the current request
- alu_result  out  DW  combinational ALU result
- status_out  out  4  registered flags {Z,N,C,V}
- pc_out  out  AW  current PC
- halted  out  1  core in HALT
- instr_count  out  32  retired instructions (optional feature)

Behaviour:
- Instruction fields, MSB to LSB: LA[1], LB[1], SA[2], SB[2], ALU_S[3], MRD[1], MWR[1], JC[3], k[DW].
- Mux A sources: SA 0 = A, 1 = B, 2 = 1, 3 = 0.
- Mux B sources: SB 0 = B, 1 = dm_rdata, 2 = k, 3 = 0.
- ALU_S: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a, 7 SHR a. Results are DW bits, wrap modulo 2^DW.
- Flags:
  - Z = result==0; N = result[DW-1].
  - C = carry-out for ADD, no-borrow (a>=b) for SUB, shifted-out bit for shifts, 0 otherwise.
  - V = signed overflow for ADD/SUB, 0 otherwise.
- JC (tests registered status, i.e. the previous committed instruction): 0 never, 1 always, 2 Z, 3 !Z, 4 N, 5 !N, 6 C, 7 !C. Target = k[AW-1:0].
- Commit (one edge):
  - If LA, A <= alu_result; if LB, B <= alu_result.
  - status <= ALU flags, on every commit.
  - pc <= target if jump taken, else pc+1 (wraps 2^AW-1 -> 0).
  - instr_count++.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN, MRD=MWR=0, not halt: commit this cycle. Latency 1 cycle/instruction.
  - RUN, MRD or MWR = 1: no commit; go to MEM_WAIT; pc and registers held.
  - MEM_WAIT: dm_req=1, dm_we=MWR; outputs stable until dm_ready. On the dm_ready cycle: commit (SB=1 uses dm_rdata live), return to RUN, dm_req drops the next cycle. Minimum 2 cycles per memory instruction.
  - MRD and MWR both 1: treated as write; dm_rdata ignored.
  - Halt: in RUN, JC=1 and target==pc -> HALT with no commit, halted=1. HALT exits only via rst.
- Reset: pc=0, A=B=0, status=0, state=RUN, dm_req=0, halted=0, instr_count=0.
- rst during MEM_WAIT aborts the request: dm_req=0 the next cycle, and a dm_ready seen in the rst cycle is ignored.
- dm_ready outside MEM_WAIT is ignored.

Optional Feature:
- CPU_PERF_CNT_EN defined: instr_count is a 32-bit counter of commits, wraps at 2^32, cleared by rst, frozen in HALT.
- Undefined: no counter logic; instr_count tied to 0.

Test Plan:
- Reset then {LA=1,SA=3,SB=2,ALU_S=ADD,k=5}, then {LB=1,SA=0,SB=2,ADD,k=3} -> A=5 after edge 1, B=8 after edge 2, pc=2, status=0000.
- A=0x7F; {LA=1,SA=0,SB=2,ADD,k=1} -> A=0x80, status Z=0,N=1,C=0,V=1; next instr JC=4,k=0x10 -> pc=0x10.
- A=0x00; SUB with k=1 -> A=0xFF, C=0, N=1; JC=6 not taken -> pc+1.
- MRD instr {LA=1,SA=3,SB=1,ADD,k=0x20}, dm_ready held low 3 cycles then high with dm_rdata=0x5A -> dm_req=1 for 4 cycles, dm_addr=0x20, dm_we=0, A=0x5A, pc+1.
- MWR with A=0x33, k=0x40 -> dm_we=1, dm_wdata=0x33, dm_addr=0x40; rst asserted mid-wait -> dm_req=0 next cycle, pc=0.
- pc=7 with {JC=1,k=7} -> halted=1, pc stays 7, no further commits; with CPU_PERF_CNT_EN, instr_count frozen.
